// File: rtl/ctx_switch_unit_pkg.sv
// ctx_switch_unit_pkg: shared widths, stride and state encoding for the context save/restore engine
`ifndef XLEN
`define XLEN 64
`endif

package ctx_switch_unit_pkg;
  localparam int CTX_XLEN = `XLEN;
  localparam int CTX_NREGS = 31;
  localparam int CTX_STRIDE = CTX_XLEN / 8;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_LOAD,
    ST_DONE
  } ctx_state_e;
endpackage

// File: rtl/ctx_addr_gen.sv
// ctx_addr_gen: register index counter and base + (k-1)*stride word address
module ctx_addr_gen
  import ctx_switch_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NREGS = CTX_NREGS,
  localparam int KW = $clog2(NREGS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [KW-1:0]     k_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) k_o <= '0;
    else if (clr_i) k_o <= KW'(1);
    else if (inc_i) k_o <= k_o + KW'(1);

  // address arithmetic wraps silently at ADDR_W bits
  assign addr_o = base_i + ADDR_W'(k_o - KW'(1)) * ADDR_W'(CTX_STRIDE);
  assign last_o = k_o == KW'(NREGS);
endmodule

// File: rtl/ctx_switch_unit.sv
// ctx_switch_unit: saves the regfile context to memory and restores it, stalling the pipeline while busy
module ctx_switch_unit
  import ctx_switch_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NREGS = CTX_NREGS
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                save_req_i,
  input  logic                restore_req_i,
  input  logic [ADDR_W-1:0]   save_base_i,
  input  logic [ADDR_W-1:0]   restore_base_i,
  input  logic [CTX_XLEN-1:0] ctx_data_i [1:NREGS],
  output logic [CTX_XLEN-1:0] ctx_data_o [1:NREGS],
  output logic                ctx_re_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [CTX_XLEN-1:0] mem_wdata_o,
  input  logic                mem_rvalid_i,
  input  logic [CTX_XLEN-1:0] mem_rdata_i,
  output logic                stall_o,
  output logic                busy_o,
  output logic                done_o
);
  localparam int KW = $clog2(NREGS + 1);

  ctx_state_e state_q, state_d;
  logic swap_q;
  logic [ADDR_W-1:0] sbase_q, rbase_q, base, addr;
  logic [CTX_XLEN-1:0] snap_q [1:NREGS];
  logic [CTX_XLEN-1:0] buf_q [1:NREGS];
  logic clr, inc, last;
  logic [KW-1:0] k;

  assign base = (state_q == ST_RD_REQ || state_q == ST_RD_WAIT) ? rbase_q : sbase_q;

  ctx_addr_gen #(.ADDR_W(ADDR_W), .NREGS(NREGS)) u_addr_gen (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (clr),
    .inc_i (inc),
    .base_i(base),
    .k_o   (k),
    .addr_o(addr),
    .last_o(last)
  );

  always_comb begin
    state_d = state_q;
    clr = 1'b0;
    inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = save_req_i ? ST_SNAP : restore_req_i ? ST_RD_REQ : ST_IDLE;
        clr = !save_req_i && restore_req_i;
      end
      // the regfile snapshot lags a cycle, so the buffer is captured as SNAP ends
      ST_SNAP: begin
        state_d = ST_WR_REQ;
        clr = 1'b1;
      end
      ST_WR_REQ: state_d = mem_req_ready_i ? ST_WR_WAIT : ST_WR_REQ;
      ST_WR_WAIT: if (mem_rvalid_i) begin
        state_d = !last ? ST_WR_REQ : swap_q ? ST_RD_REQ : ST_DONE;
        inc = !last;
        clr = last && swap_q;
      end
      ST_RD_REQ: state_d = mem_req_ready_i ? ST_RD_WAIT : ST_RD_REQ;
      ST_RD_WAIT: if (mem_rvalid_i) begin
        state_d = last ? ST_LOAD : ST_RD_REQ;
        inc = !last;
      end
      ST_LOAD: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      swap_q <= 1'b0;
      sbase_q <= '0;
      rbase_q <= '0;
      snap_q <= '{default: '0};
      buf_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && (save_req_i || restore_req_i)) begin
        swap_q <= save_req_i && restore_req_i;
        sbase_q <= save_base_i;
        rbase_q <= restore_base_i;
      end
      if (state_q == ST_SNAP) snap_q <= ctx_data_i;
      if (state_q == ST_RD_WAIT && mem_rvalid_i) buf_q[k] <= mem_rdata_i;
    end

  assign busy_o = state_q != ST_IDLE;
  assign stall_o = busy_o && state_q != ST_DONE;
  assign done_o = state_q == ST_DONE;
  assign ctx_re_o = state_q == ST_LOAD;
  assign mem_req_valid_o = state_q == ST_WR_REQ || state_q == ST_RD_REQ;
  assign mem_we_o = state_q == ST_WR_REQ;
  assign mem_addr_o = mem_req_valid_o ? addr : '0;
  assign mem_wdata_o = mem_we_o ? snap_q[k] : '0;
  assign ctx_data_o = buf_q;
endmodule

// File: tb/tb_ctx_switch_unit.sv
// tb_ctx_switch_unit: directed save/restore/swap/backpressure/reset/wrap vectors against a small memory responder
module tb_ctx_switch_unit;
  import ctx_switch_unit_pkg::*;
  localparam int AW = 32;
  localparam int N = CTX_NREGS;
  localparam int XL = CTX_XLEN;

  logic clk_i = 1'b0, rst_ni = 1'b1;
  logic save_req_i = 1'b0, restore_req_i = 1'b0, mem_req_ready_i = 1'b1, mem_rvalid_i = 1'b0;
  logic [AW-1:0] save_base_i = '0, restore_base_i = '0, mem_addr_o;
  logic [XL-1:0] ctx_data_i [1:N];
  logic [XL-1:0] ctx_data_o [1:N];
  logic [XL-1:0] mem_wdata_o, mem_rdata_i = '0;
  logic ctx_re_o, mem_req_valid_o, mem_we_o, stall_o, busy_o, done_o;

  int errs = 0, checks = 0, cyc = 0;
  int rq_n = 0, re_cnt = 0, done_cnt = 0, re_cyc = 0, done_cyc = 0, start_cyc = 0;
  int dly = 0, hold = 0, bp_chk_n = 0, bp_k = 5;
  logic stall_at_done = 1'b0, pend = 1'b0;
  bit bp_on = 1'b0, bp_seen = 1'b0;
  logic log_we [0:127];
  logic [AW-1:0] log_addr [0:127];
  logic [XL-1:0] log_wd [0:127];
  logic [XL-1:0] re_data [1:N];
  logic [AW-1:0] rbase = '0, h_addr = '0;
  logic [XL-1:0] h_wd = '0, rword = '0, mem_tag = '0;

  ctx_switch_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .save_req_i(save_req_i), .restore_req_i(restore_req_i),
    .save_base_i(save_base_i), .restore_base_i(restore_base_i),
    .ctx_data_i(ctx_data_i), .ctx_data_o(ctx_data_o), .ctx_re_o(ctx_re_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int k);
    return base + AW'((k - 1) * CTX_STRIDE);
  endfunction

  always @(negedge clk_i) begin
    if (ctx_re_o) begin
      re_cnt++;
      re_cyc = cyc;
      for (int i = 1; i <= N; i++) re_data[i] = ctx_data_o[i];
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
      stall_at_done = stall_o;
    end
  end

  // one-outstanding memory: rvalid a cycle after acceptance, optional stall/delay on request bp_k
  always @(negedge clk_i) begin
    mem_rvalid_i = 1'b0;
    if (!rst_ni) begin
      pend = 1'b0;
      hold = 0;
      mem_req_ready_i = 1'b1;
    end else if (pend) begin
      if (bp_on) chk("no_req_while_waiting", mem_req_valid_o, 0);
      if (dly == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i = rword;
        pend = 1'b0;
      end else dly--;
    end else if (mem_req_valid_o) begin
      if (bp_on && rq_n == bp_k - 1) begin
        if (!bp_seen) begin
          bp_seen = 1'b1;
          hold = 3;
          h_addr = mem_addr_o;
          h_wd = mem_wdata_o;
        end else begin
          bp_chk_n++;
          chk("bp_addr_stable", mem_addr_o, h_addr);
          chk("bp_wdata_stable", mem_wdata_o, h_wd);
        end
      end
      if (hold > 0) begin
        mem_req_ready_i = 1'b0;
        hold--;
      end else begin
        mem_req_ready_i = 1'b1;
        if (rq_n < 128) begin
          log_we[rq_n] = mem_we_o;
          log_addr[rq_n] = mem_addr_o;
          log_wd[rq_n] = mem_wdata_o;
        end
        rword = mem_tag + XL'((mem_addr_o - rbase) / CTX_STRIDE) + 1;
        rq_n++;
        pend = 1'b1;
        dly = (bp_on && rq_n == bp_k) ? 4 : 0;
      end
    end else mem_req_ready_i = 1'b1;
  end

  task automatic start(input logic s, input logic r);
    @(negedge clk_i);
    rq_n = 0;
    re_cnt = 0;
    done_cnt = 0;
    bp_chk_n = 0;
    bp_seen = 1'b0;
    save_req_i = s;
    restore_req_i = r;
    start_cyc = cyc;
    chk("idle_before_accept", busy_o, 0);
    @(negedge clk_i);
    save_req_i = 1'b0;
    restore_req_i = 1'b0;
    chk("busy_after_accept", busy_o, 1);
    chk("stall_after_accept", stall_o, 1);
  endtask

  // latency is numbered with the request cycle as cycle 1
  task automatic wait_done(input int exp_lat);
    for (int i = 0; i < 600 && done_cnt == 0; i++) @(negedge clk_i);
    chk("done_pulse", done_cnt, 1);
    chk("latency", done_cyc - start_cyc + 1, exp_lat);
    chk("stall_low_in_done", stall_at_done, 0);
    repeat (3) @(negedge clk_i);
    chk("idle_after_done", busy_o, 0);
    chk("single_done", done_cnt, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 1; k <= N; k++) ctx_data_i[k] = XL'(64'h100 + k);
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_re", ctx_re_o, 0);
    chk("rst_valid", mem_req_valid_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_buf", ctx_data_o[1], 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    save_base_i = 32'h1000;
    start(1'b1, 1'b0);
    wait_done(65);
    chk("save_writes", rq_n, N);
    chk("save_no_load", re_cnt, 0);
    for (int k = 1; k <= N; k++) begin
      chk($sformatf("save_we[%0d]", k), log_we[k-1], 1);
      chk($sformatf("save_addr[%0d]", k), log_addr[k-1], exp_addr(32'h1000, k));
      chk($sformatf("save_data[%0d]", k), log_wd[k-1], 64'h100 + k);
    end

    mem_tag = 64'hA000;
    restore_base_i = 32'h2000;
    rbase = 32'h2000;
    start(1'b0, 1'b1);
    wait_done(65);
    chk("rest_reads", rq_n, N);
    chk("rest_load_pulses", re_cnt, 1);
    chk("rest_load_to_done", done_cyc - re_cyc, 1);
    for (int k = 1; k <= N; k++) begin
      chk($sformatf("rest_we[%0d]", k), log_we[k-1], 0);
      chk($sformatf("rest_addr[%0d]", k), log_addr[k-1], exp_addr(32'h2000, k));
      chk($sformatf("rest_buf[%0d]", k), re_data[k], 64'hA000 + k);
    end
    chk("rest_buf_stable", ctx_data_o[N], 64'hA000 + N);

    for (int k = 1; k <= N; k++) ctx_data_i[k] = XL'(64'h200 + k);
    mem_tag = 64'hD000;
    save_base_i = 32'h3000;
    restore_base_i = 32'h4000;
    rbase = 32'h4000;
    start(1'b1, 1'b1);
    wait_done(128);
    chk("swap_reqs", rq_n, 2 * N);
    chk("swap_load_pulses", re_cnt, 1);
    for (int k = 1; k <= N; k++) begin
      chk($sformatf("swap_wr_we[%0d]", k), log_we[k-1], 1);
      chk($sformatf("swap_wr_addr[%0d]", k), log_addr[k-1], exp_addr(32'h3000, k));
      chk($sformatf("swap_wr_data[%0d]", k), log_wd[k-1], 64'h200 + k);
      chk($sformatf("swap_rd_we[%0d]", k), log_we[N+k-1], 0);
      chk($sformatf("swap_rd_addr[%0d]", k), log_addr[N+k-1], exp_addr(32'h4000, k));
      chk($sformatf("swap_buf[%0d]", k), re_data[k], 64'hD000 + k);
    end

    bp_on = 1'b1;
    save_base_i = 32'h1000;
    start(1'b1, 1'b0);
    wait_done(72);
    bp_on = 1'b0;
    chk("bp_hold_cycles", bp_chk_n, 3);
    chk("bp_writes", rq_n, N);
    chk("bp_addr5", log_addr[4], 32'h1020);
    chk("bp_data5", log_wd[4], 64'h205);
    chk("bp_addr6", log_addr[5], 32'h1028);

    mem_tag = 64'hB000;
    restore_base_i = 32'h2000;
    rbase = 32'h2000;
    start(1'b0, 1'b1);
    for (int i = 0; i < 200 && rq_n < 11; i++) @(negedge clk_i);
    chk("mid_loaded", ctx_data_o[5], 64'hB005);
    chk("mid_untouched", ctx_data_o[20], 64'hD014);
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("abort_valid", mem_req_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_stall", stall_o, 0);
    chk("abort_re", ctx_re_o, 0);
    chk("abort_addr", mem_addr_o, 0);
    chk("abort_buf", ctx_data_o[5], 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("abort_no_load", re_cnt, 0);
    chk("abort_idle", busy_o, 0);
    mem_tag = 64'hC000;
    restore_base_i = 32'h5000;
    rbase = 32'h5000;
    start(1'b0, 1'b1);
    wait_done(65);
    chk("fresh_load_pulses", re_cnt, 1);
    chk("fresh_addr1", log_addr[0], 32'h5000);
    for (int k = 1; k <= N; k++) chk($sformatf("fresh_buf[%0d]", k), re_data[k], 64'hC000 + k);

    save_base_i = 32'hFFFF_FFF8;
    start(1'b1, 1'b0);
    repeat (5) @(negedge clk_i);
    save_req_i = 1'b1;
    restore_req_i = 1'b1;
    restore_base_i = 32'h6000;
    @(negedge clk_i);
    save_req_i = 1'b0;
    restore_req_i = 1'b0;
    wait_done(65);
    chk("busy_req_ignored_cnt", rq_n, N);
    for (int k = 1; k <= N; k++) chk($sformatf("busy_req_we[%0d]", k), log_we[k-1], 1);
    chk("wrap_addr1", log_addr[0], 32'hFFFF_FFF8);
    chk("wrap_addr2", log_addr[1], 32'h0);
    chk("wrap_addr3", log_addr[2], 32'h8);
    chk("wrap_addr31", log_addr[N-1], 32'hE8);
    repeat (10) @(negedge clk_i);
    chk("not_queued_busy", busy_o, 0);
    chk("not_queued_done", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
